// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution core: width arithmetic and
// output-mode encodings.
package conv_pkg;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_SAT = 1'b1;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

  function automatic int kk_of(input int ksize);
    return ksize * ksize;
  endfunction

  // Wide enough that a full K*K sum of extreme products cannot overflow.
  function automatic int out_w_of(input int data_w, input int coef_w, input int ksize);
    return data_w + coef_w + 1 + clog2(ksize * ksize);
  endfunction

endpackage

// File: rtl/conv_window_buf.sv
// Raster position tracking, KSIZE-1 line buffers and the KxK sliding window.
// The window is flattened raster order: entry r*KSIZE+c is row r, column c.
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 5,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            adv,
  input  logic                            accept,
  input  logic [DATA_W-1:0]               pix,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   window,
  output logic                            window_valid,
  output logic                            window_last,
  output logic                            frame_start
);

  localparam int COL_W = clog2(IMG_W);
  localparam int ROW_W = clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KSIZE - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KSIZE - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] line_mem [KSIZE-1][IMG_W];
  logic [DATA_W-1:0] col_pix  [KSIZE];
  logic [DATA_W-1:0] win      [KSIZE][KSIZE];

  assign frame_start = (row == '0) && (col == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Newest column of the window: the incoming pixel at the bottom, older rows
  // from the line buffers above it (line_mem[0] is the previous row).
  always_comb begin
    col_pix = '{default: '0};
    col_pix[KSIZE-1] = pix;
    for (int i = 0; i < KSIZE-1; i++) begin
      col_pix[KSIZE-2-i] = line_mem[i][col];
    end
  end

  // Line buffers cascade: each accepted pixel pushes its column down one row.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][col] <= pix;
      for (int i = 1; i < KSIZE-1; i++) begin
        line_mem[i][col] <= line_mem[i-1][col];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE-1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][KSIZE-1] <= col_pix[r];
      end
    end
  end

  always_comb begin
    window = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        window[(r*KSIZE+c)*DATA_W +: DATA_W] = win[r][c];
      end
    end
  end

  // Windows that would straddle the top or left edge are never emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_valid <= 1'b0;
      window_last  <= 1'b0;
    end else if (adv) begin
      window_valid <= accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
      window_last  <= accept && (row == ROW_LAST) && (col == COL_LAST);
    end
  end

endmodule

// File: rtl/conv_filter_core.sv
// KxK streaming convolution: double-buffered signed kernel, three-stage MAC
// pipeline and raw or shifted/saturated output, with full output backpressure.
module conv_filter_core
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int KSIZE  = 5,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  localparam int KK    = kk_of(KSIZE),
  localparam int OUT_W = out_w_of(DATA_W, COEF_W, KSIZE)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_coef_valid,
  input  logic signed [COEF_W-1:0] i_coef_data,
  output logic                     o_coef_ready,
  input  logic                     i_mode,
  input  logic [4:0]               i_shift,
  input  logic                     i_pix_valid,
  input  logic [DATA_W-1:0]        i_pix_data,
  output logic                     o_pix_ready,
  output logic                     o_valid,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_last,
  input  logic                     i_ready,
  output logic                     o_frame_done
);

  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int CNT_W  = clog2(KK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KK - 1);
  localparam logic signed [OUT_W-1:0] PIX_MAX = OUT_W'((1 << DATA_W) - 1);

  logic signed [COEF_W-1:0] shadow [KK];
  logic signed [COEF_W-1:0] active [KK];
  logic [CNT_W-1:0]         coef_cnt;
  logic                     pending;
  logic                     active_valid;
  logic                     mode_q;
  logic [4:0]               shift_q;

  logic [KK*DATA_W-1:0]     window;
  logic                     window_valid;
  logic                     window_last;
  logic                     frame_start;

  logic signed [PROD_W-1:0] prod     [KK];
  logic signed [PROD_W-1:0] s1_prod  [KK];
  logic signed [OUT_W-1:0]  part     [KSIZE];
  logic signed [OUT_W-1:0]  s2_part  [KSIZE];
  logic signed [OUT_W-1:0]  total;
  logic signed [OUT_W-1:0]  shifted;
  logic [OUT_W-1:0]         result;
  logic                     s1_valid, s1_last, s2_valid, s2_last;

  logic stall, pix_accept, coef_accept, pipe_empty, swap;

  // Valid/ready: a beat transfers on a rising edge where valid && ready are
  // both high; the sender holds valid and payload stable until that edge.
  // Every stage freezes while an output beat waits on downstream ready.
  assign stall        = o_valid && !i_ready;
  assign pix_accept   = i_pix_valid && o_pix_ready;
  assign coef_accept  = i_coef_valid && o_coef_ready;
  assign pipe_empty   = !window_valid && !s1_valid && !s2_valid && !o_valid;
  assign swap         = pending && frame_start && pipe_empty;
  assign o_coef_ready = !pending;
  assign o_pix_ready  = active_valid && !stall && !(pending && frame_start);
  assign o_frame_done = o_valid && i_ready && o_last;

  always_ff @(posedge i_clk) begin
    if (coef_accept) shadow[coef_cnt] <= i_coef_data;
    if (swap)        active <= shadow;
  end

  // Mode and shift are captured only at the swap so a frame never changes
  // arithmetic part way through.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coef_cnt     <= '0;
      pending      <= 1'b0;
      active_valid <= 1'b0;
      mode_q       <= MODE_RAW;
      shift_q      <= '0;
    end else begin
      if (coef_accept) begin
        if (coef_cnt == CNT_LAST) begin
          coef_cnt <= '0;
          pending  <= 1'b1;
        end else begin
          coef_cnt <= coef_cnt + 1'b1;
        end
      end
      if (swap) begin
        pending      <= 1'b0;
        active_valid <= 1'b1;
        mode_q       <= i_mode;
        shift_q      <= i_shift;
      end
    end
  end

  conv_window_buf #(
    .DATA_W (DATA_W),
    .KSIZE  (KSIZE),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) u_window_buf (
    .clk          (i_clk),
    .rst          (i_rst),
    .adv          (!stall),
    .accept       (pix_accept),
    .pix          (i_pix_data),
    .window       (window),
    .window_valid (window_valid),
    .window_last  (window_last),
    .frame_start  (frame_start)
  );

  // Pixels are unsigned, so a zero top bit keeps the signed multiply honest.
  always_comb begin
    prod = '{default: '0};
    for (int k = 0; k < KK; k++) begin
      prod[k] = PROD_W'($signed({1'b0, window[k*DATA_W +: DATA_W]})) * PROD_W'(active[k]);
    end
  end

  always_comb begin
    part = '{default: '0};
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        part[r] = part[r] + OUT_W'(s1_prod[r*KSIZE+c]);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int r = 0; r < KSIZE; r++) begin
      total = total + s2_part[r];
    end
    shifted = total >>> shift_q;
    result  = total;
    if (mode_q == MODE_SAT) begin
      if (shifted[OUT_W-1])       result = '0;
      else if (shifted > PIX_MAX) result = PIX_MAX;
      else                        result = shifted;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!stall) begin
      s1_prod <= prod;
      s2_part <= part;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else if (!stall) begin
      s1_valid <= window_valid;
      s1_last  <= window_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      o_valid  <= s2_valid;
      o_last   <= s2_valid && s2_last;
      if (s2_valid) o_data <= result;
    end
  end

endmodule

// File: tb/tb_conv_filter_core.sv
// Directed bench for conv_filter_core at KSIZE=3 on an 8x6 image; expected
// beats are queued by the drivers and checked by an independent monitor.
module tb_conv_filter_core;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int KSIZE  = 3;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int KK     = 9;
  localparam int OUT_W  = 21;   // 8 + 8 + 1 + clog2(9)
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = 24;

  localparam int K_IDENT   = 0;
  localparam int K_TOPLEFT = 1;
  localparam int K_CONST   = 2;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic                     i_coef_valid = 1'b0;
  logic signed [COEF_W-1:0] i_coef_data  = '0;
  logic                     o_coef_ready;
  logic                     i_mode       = 1'b0;
  logic [4:0]               i_shift      = '0;
  logic                     i_pix_valid  = 1'b0;
  logic [DATA_W-1:0]        i_pix_data   = '0;
  logic                     o_pix_ready;
  logic                     o_valid;
  logic [OUT_W-1:0]         o_data;
  logic                     o_last;
  logic                     i_ready      = 1'b1;
  logic                     o_frame_done;

  conv_filter_core #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .KSIZE  (KSIZE),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_coef_valid (i_coef_valid),
    .i_coef_data  (i_coef_data),
    .o_coef_ready (o_coef_ready),
    .i_mode       (i_mode),
    .i_shift      (i_shift),
    .i_pix_valid  (i_pix_valid),
    .i_pix_data   (i_pix_data),
    .o_pix_ready  (o_pix_ready),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_last       (o_last),
    .i_ready      (i_ready),
    .o_frame_done (o_frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W:0] exp_q[$];     // {last, data}
  logic [OUT_W:0] exp_item;
  logic [7:0]     kern [KK];
  int chk_cnt = 0;
  int pass_cnt = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  int acc_cyc_18 = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (i_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_output: got data 0x%0h last %0b with no beat expected", o_data, o_last);
        end else begin
          exp_item = exp_q.pop_front();
          check("out_data", 64'(o_data), 64'(exp_item[OUT_W-1:0]));
          check("out_last", 64'(o_last), 64'(exp_item[OUT_W]));
          check("out_frame_done", 64'(o_frame_done), 64'(exp_item[OUT_W]));
        end
      end
    end
    if (!i_rst && o_frame_done) done_cnt++;
  end

  // ---------------- expected-value generation ----------------
  // Pixel value p = row*8 + col; a window ending at (r,c) covers rows r-2..r.
  function automatic void push_frame(input int kind, input logic [OUT_W-1:0] cval, input int npix);
    logic [OUT_W-1:0] v;
    for (int r = KSIZE-1; r < IMG_H; r++) begin
      for (int c = KSIZE-1; c < IMG_W; c++) begin
        if (r*IMG_W + c < npix) begin
          if (kind == K_IDENT)        v = OUT_W'((r-1)*IMG_W + (c-1));
          else if (kind == K_TOPLEFT) v = OUT_W'((r-2)*IMG_W + (c-2));
          else                        v = cval;
          exp_q.push_back({(r == IMG_H-1) && (c == IMG_W-1), v});
        end
      end
    end
  endfunction

  function automatic void set_kern(input int kind);
    for (int i = 0; i < KK; i++) begin
      case (kind)
        0:       kern[i] = (i == 4) ? 8'd1 : 8'd0;
        1:       kern[i] = (i == 0) ? 8'd1 : 8'd0;
        2:       kern[i] = 8'd1;
        default: kern[i] = 8'hFF;
      endcase
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    i_rst = 1'b1;
    i_pix_valid = 1'b0;
    i_coef_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic load_kernel();
    int n;
    for (int i = 0; i < KK; i++) begin
      n = 0;
      i_coef_valid = 1'b1;
      i_coef_data  = kern[i];
      @(negedge i_clk);
      while (!o_coef_ready && n < 300) begin
        @(negedge i_clk);
        n++;
      end
      if (!o_coef_ready) begin
        chk_cnt++;
        $display("FAIL coef_ready_timeout: got ready 0 after %0d cycles, expected 1", n);
        i_coef_valid = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
    end
    i_coef_valid = 1'b0;
    check("coef_ready_after_9th_write", 64'(o_coef_ready), 64'd0);
  endtask

  task automatic send_pixels(input bit const_img, input logic [7:0] cval, input int npix);
    int n;
    for (int p = 0; p < npix; p++) begin
      n = 0;
      i_pix_valid = 1'b1;
      i_pix_data  = const_img ? cval : 8'(p);
      @(negedge i_clk);
      while (!o_pix_ready && n < 500) begin
        @(negedge i_clk);
        n++;
      end
      if (!o_pix_ready) begin
        chk_cnt++;
        $display("FAIL pix_ready_timeout: got ready 0 at pixel %0d, expected 1", p);
        i_pix_valid = 1'b0;
        return;
      end
      @(posedge i_clk);
      #1;
      if (p == 18) acc_cyc_18 = cyc;
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic run_frame(input int kind, input bit const_img, input logic [7:0] cval,
                           input logic [OUT_W-1:0] eval, input string tag);
    out_cnt  = 0;
    done_cnt = 0;
    push_frame(kind, eval, NPIX);
    send_pixels(const_img, cval, NPIX);
    wait_drain();
    check({tag, "_out_count"}, 64'(out_cnt), 64'(NOUT));
    check({tag, "_frame_done_count"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic idle_no_kernel(input int cycles, input string tag);
    int rdy_seen;
    int val_seen;
    rdy_seen = 0;
    val_seen = 0;
    i_pix_valid = 1'b1;
    i_pix_data  = 8'h55;
    repeat (cycles) begin
      @(negedge i_clk);
      if (o_pix_ready) rdy_seen++;
      if (o_valid) val_seen++;
    end
    i_pix_valid = 1'b0;
    check({tag, "_pix_ready_cycles"}, 64'(rdy_seen), 64'd0);
    check({tag, "_valid_cycles"}, 64'(val_seen), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic stall_burst();
    int n;
    int bad_v;
    int bad_d;
    int bad_r;
    logic [OUT_W-1:0] held;
    n = 0;
    bad_v = 0;
    bad_d = 0;
    bad_r = 0;
    while (!(o_valid && out_cnt >= 5) && n < 300) begin
      @(posedge i_clk);
      #3;
      n++;
    end
    if (!(o_valid && out_cnt >= 5)) begin
      chk_cnt++;
      $display("FAIL stall_setup_timeout: got out_cnt %0d valid %0b, expected valid with >=5 beats", out_cnt, o_valid);
      return;
    end
    held = o_data;
    i_ready = 1'b0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_valid !== 1'b1) bad_v++;
      if (o_data !== held) bad_d++;
      if (o_pix_ready !== 1'b0) bad_r++;
    end
    @(posedge i_clk);
    #3;
    i_ready = 1'b1;
    check("stall_valid_dropped", 64'(bad_v), 64'd0);
    check("stall_data_changed", 64'(bad_d), 64'd0);
    check("stall_pix_ready_high", 64'(bad_r), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_last", 64'(o_last), 64'd0);
    check("rst_o_frame_done", 64'(o_frame_done), 64'd0);
    check("rst_o_data", 64'(o_data), 64'd0);
    check("rst_o_coef_ready", 64'(o_coef_ready), 64'd1);
    check("rst_o_pix_ready", 64'(o_pix_ready), 64'd0);

    idle_no_kernel(100, "nokernel");

    // Identity kernel, raw mode
    i_mode = 1'b0; i_shift = 5'd0;
    set_kern(0);
    load_kernel();
    first_valid_cyc = -1;
    acc_cyc_18 = -1;
    run_frame(K_IDENT, 1'b0, 8'd0, '0, "ident");
    check("ident_latency", 64'(first_valid_cyc - acc_cyc_18), 64'd3);

    // Box kernel on a flat 200 image: 9*200 = 1800
    i_mode = 1'b1; i_shift = 5'd3;
    set_kern(2);
    load_kernel();
    run_frame(K_CONST, 1'b1, 8'd200, OUT_W'(225), "box_sh3");

    i_mode = 1'b1; i_shift = 5'd0;
    load_kernel();
    run_frame(K_CONST, 1'b1, 8'd200, OUT_W'(255), "box_sat");

    i_mode = 1'b0; i_shift = 5'd0;
    load_kernel();
    run_frame(K_CONST, 1'b1, 8'd200, OUT_W'(1800), "box_raw");

    // All -1 kernel on a flat 10 image: sum -90
    i_mode = 1'b0;
    set_kern(3);
    load_kernel();
    run_frame(K_CONST, 1'b1, 8'd10, 21'h1F_FFA6, "neg_raw");

    i_mode = 1'b1; i_shift = 5'd0;
    load_kernel();
    run_frame(K_CONST, 1'b1, 8'd10, OUT_W'(0), "neg_sat");

    // Identity again with a downstream stall in the middle of the frame
    i_mode = 1'b0;
    set_kern(0);
    load_kernel();
    out_cnt  = 0;
    done_cnt = 0;
    push_frame(K_IDENT, '0, NPIX);
    fork
      send_pixels(1'b0, 8'd0, NPIX);
      stall_burst();
    join
    wait_drain();
    check("stall_out_count", 64'(out_cnt), 64'(NOUT));
    check("stall_frame_done_count", 64'(done_cnt), 64'd1);

    // Frame 1 on the identity kernel while the top-left kernel loads behind it
    out_cnt  = 0;
    done_cnt = 0;
    push_frame(K_IDENT, '0, NPIX);
    push_frame(K_TOPLEFT, '0, 30);
    set_kern(1);
    fork
      send_pixels(1'b0, 8'd0, NPIX);
      begin
        repeat (10) @(posedge i_clk);
        #1;
        load_kernel();
      end
    join
    check("coef_ready_held_before_swap", 64'(o_coef_ready), 64'd0);
    send_pixels(1'b0, 8'd0, 30);
    check("coef_ready_after_swap", 64'(o_coef_ready), 64'd1);
    wait_drain();
    check("swap_out_count", 64'(out_cnt), 64'(NOUT + 10));
    check("swap_frame_done_count", 64'(done_cnt), 64'd1);

    // Reset in the middle of frame 2 drops the kernel and position
    do_reset();
    check("rst2_o_valid", 64'(o_valid), 64'd0);
    check("rst2_o_coef_ready", 64'(o_coef_ready), 64'd1);
    check("rst2_o_pix_ready", 64'(o_pix_ready), 64'd0);
    idle_no_kernel(50, "postrst");

    i_mode = 1'b0; i_shift = 5'd0;
    set_kern(0);
    load_kernel();
    run_frame(K_IDENT, 1'b0, 8'd0, '0, "postrst_ident");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_filter_core.md
Name: conv_filter_core

Overview:
- Parametrised K×K streaming 2-D convolution core.
- Accepts a raster pixel stream with valid/ready flow control, builds K×K windows from internal line buffers, and multiply-accumulates them against a double-buffered signed kernel.
- Emits either the full-precision result or a shifted, saturated pixel, with full output backpressure.
- Sits between the pixel DMA/stream front end and the result writer; replaces the fixed 5×5, no-backpressure filter top.

Parameters:
DATA_W, 8, unsigned pixel width
COEF_W, 8, signed coefficient width
KSIZE, 5, kernel edge; odd, 3..7
IMG_W, 512, pixels per row; must be >= KSIZE
IMG_H, 512, rows per frame; must be >= KSIZE

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_coef_valid  in  1  coefficient write strobe
i_coef_data  in  COEF_W  signed coefficient, raster order (index 0 = top-left)
o_coef_ready  out  1  shadow bank accepting coefficients
i_mode  in  1  0 = raw signed sum, 1 = shift+saturate
i_shift  in  5  arithmetic right shift, used when i_mode=1
i_pix_valid  in  1  input pixel valid
i_pix_data  in  DATA_W  input pixel
o_pix_ready  out  1  pixel accepted when valid&&ready
o_valid  out  1  output valid
o_data  out  OUT_W  result (OUT_W from package)
o_last  out  1  last output of frame
i_ready  in  1  downstream ready
o_frame_done  out  1  one-cycle pulse on transfer of the o_last beat

Behaviour:
- Reset:
  - o_valid, o_last, o_frame_done = 0; o_data = 0.
  - o_coef_ready = 1; o_pix_ready = 0.
  - Both kernel banks invalid; coef count, row and col counters = 0; pipeline valids cleared.
  - Line-buffer RAM is not reset; row/col gating makes stale contents irrelevant.
  - Reset mid-frame aborts the frame with no further outputs.
- Kernel load:
  - Each i_coef_valid&&o_coef_ready writes shadow[count] and increments count.
  - On write KK-1 (KK = KSIZE²): count wraps to 0, pending = 1, o_coef_ready = 0.
- Kernel swap:
  - Fires when pending && row=0 && col=0 && pipeline empty; takes 1 cycle.
  - Copies shadow to active, sets active_valid, clears pending, and latches i_mode/i_shift for the frame.
  - While pending at frame start, o_pix_ready = 0 until the swap cycle completes.
  - A frame in progress always finishes with its original kernel and mode.
- Stall: stall = o_valid && !i_ready. Every pipeline stage, the window and the counters freeze during stall.
- Pixel ready: o_pix_ready = active_valid && !stall && !(pending && row=0 && col=0).
- Raster counters:
  - Each accepted pixel advances col; at col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
  - Pixel is written to the line buffer and shifted into the K×K window.
- Window validity:
  - Output is generated only for accepted pixels with row >= KSIZE-1 and col >= KSIZE-1 (valid convolution, no padding).
  - Outputs per frame: (IMG_W-KSIZE+1)×(IMG_H-KSIZE+1).
- Pipeline, fixed latency 3 unstalled cycles from accept to o_valid:
  - S1: KK signed products, pixel zero-extended to DATA_W+1.
  - S2: adder tree partial sums.
  - S3: final sum, then mode apply.
- Width rule: OUT_W = DATA_W+COEF_W+1+clog2(KK); full sum never overflows.
- Mode 1: sum >>> shift, clamp to [0, 2^DATA_W-1], zero-extended to OUT_W.
- Output hold: o_data and o_last hold stable while o_valid && !i_ready.
- Frame end:
  - o_last is set on the output from window (IMG_H-1, IMG_W-1).
  - o_frame_done pulses in the cycle that beat transfers.
- Simultaneous events:
  - A coefficient write and a swap in the same cycle is impossible, since o_coef_ready=0 while pending.
  - A coefficient write during a frame only touches the shadow bank.

Decomposition:
- conv_pkg: function clog2; localparam KK and OUT_W expressions; MODE_RAW=0 and MODE_SAT=1 constants.
- Sub-module conv_window_buf:
  - Contains KSIZE-1 line buffers of IMG_W×DATA_W, the K×K window registers and the raster counters.
  - Outputs the packed window, window_valid and window_last, with an enable input for stall.
- conv_filter_core holds the kernel banks, the MAC pipeline, mode/saturate logic and the handshake.

Test Plan (bench overrides KSIZE=3, IMG_W=8, IMG_H=6 → 24 outputs/frame):
- No kernel loaded, drive pixels → o_pix_ready stays 0, no o_valid, for 100 cycles.
- Identity kernel (centre 1, rest 0), mode 0, pixel = row*8+col:
  - → 24 outputs; first output = 9; last output = 38 with o_last=1.
  - → o_frame_done pulse; first o_valid 3 cycles after pixel (2,2) is accepted.
- Box kernel (all 1), constant image 200:
  - mode 1 shift 3 → all outputs 225.
  - mode 1 shift 0 → all outputs 255 (saturated).
  - mode 0 → all outputs 1800.
- All coefficients -1 (0xFF), image 10:
  - mode 0 → -90 in OUT_W two's complement.
  - mode 1 → 0 (clamped).
- i_ready low for 5 cycles mid-frame:
  - → o_valid and o_data stable, o_pix_ready = 0 throughout.
  - → exactly 24 outputs, sequence identical to the unstalled run.
- Second kernel loaded during frame 1, then reset asserted mid-frame 2:
  - → frame 1 uses the old kernel; o_coef_ready=0 from the 9th write until the swap.
  - → frame 2 uses the new kernel.
  - → after reset: no outputs, o_pix_ready=0 until a fresh kernel is loaded.
